// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared widths, opcode field, halt encoding and slot payload for the fetch sequencer.
package instruction_fetch_sequencer_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 11;
  localparam int unsigned OPC_W = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0]  HALT_OPCODE      = 5'h1F;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 8'h00;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_slot_t;

  function automatic logic is_halt(input logic [DATA_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/instruction_fetch_sequencer.sv
// PC sequencer feeding a combinational instruction ROM; single registered output
// slot toward decode with redirect flush and halt/resume control.
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              resume,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  fetch_slot_t       slot_q, slot_d;
  logic              slot_free;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  // Next-state: redirect overrides fetch; a stalled slot freezes everything
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    slot_d    = slot_q;
    slot_free = !valid_q || out_ready;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (slot_free) begin
            slot_d.instr = imem_data;
            slot_d.pc    = pc_q;
            valid_d      = 1'b1;
            pc_d         = pc_q + ADDR_W'(1);
            if (is_halt(imem_data)) state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          if (out_ready) valid_d = 1'b0;
          if (resume) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = valid_q;
  assign out_instr = slot_q.instr;
  assign out_pc    = slot_q.pc;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Bench for instruction_fetch_sequencer: directed scenarios then random traffic,
// all checked each cycle against a queue-based transaction model.
module tb_instruction_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        resume;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        halted;

  logic [15:0] rom [0:255];
  assign imem_data = rom[imem_addr];

  instruction_fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .resume         (resume),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one-deep queue of {pc,instr} transactions plus fetch pointer
  logic [23:0] m_slot [$];
  logic [7:0]  m_pc;
  logic        m_halt;
  logic [7:0]  m_last_pc;
  logic [15:0] m_last_instr;

  task automatic model_step();
    logic [15:0] w;
    if (reset) begin
      m_slot.delete();
      m_pc = 8'h00;
      m_halt = 1'b0;
      m_last_pc = 8'h00;
      m_last_instr = 16'h0000;
    end else begin
      if (m_slot.size() != 0 && out_ready) void'(m_slot.pop_front());
      if (redirect_valid) begin
        m_slot.delete();
        m_pc = redirect_pc;
        m_halt = 1'b0;
      end else if (!m_halt) begin
        if (m_slot.size() == 0) begin
          w = rom[m_pc];
          m_slot.push_back({m_pc, w});
          m_last_pc = m_pc;
          m_last_instr = w;
          if (w[15:11] == 5'h1F) m_halt = 1'b1;
          m_pc = m_pc + 8'd1;
        end
      end else if (resume) begin
        m_halt = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_slot.size() != 0));
    check("halted", 32'(halted), 32'(m_halt));
    check("imem_addr", 32'(imem_addr), 32'(m_pc));
    check("out_pc", 32'(out_pc), 32'(m_last_pc));
    check("out_instr", 32'(out_instr), 32'(m_last_instr));
  endtask

  task automatic expect_out(input string tag, input logic [7:0] pc, input logic [15:0] instr);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, 32'(out_pc), 32'(pc));
    check({tag, "_instr"}, 32'(out_instr), 32'(instr));
  endtask

  task automatic fill_rom(input int halt_one_in);
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (halt_one_in > 0 && $urandom_range(0, halt_one_in - 1) == 0) w = 16'hF800;
      else if (w[15:11] == 5'h1F) w[15] = 1'b0;
      rom[i] = w;
    end
  endtask

  task automatic load_production_image();
    fill_rom(0);
    rom[8'h00] = 16'h4A0A; rom[8'h01] = 16'h4E02; rom[8'h02] = 16'h4800;
    rom[8'h03] = 16'h6200; rom[8'h04] = 16'h68A8; rom[8'h07] = 16'h68A8;
    rom[8'h12] = 16'h0D80; rom[8'h15] = 16'hF800; rom[8'h16] = 16'h0000;
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00;
    resume = 1'b0; out_ready = 1'b1;
    load_production_image();
    #1;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h00);
    check("rst_halted", 32'(halted), 32'd0);

    // Streaming from reset
    reset = 1'b0;
    tick(); expect_out("s0", 8'h00, 16'h4A0A);
    tick(); expect_out("s1", 8'h01, 16'h4E02);
    tick(); expect_out("s2", 8'h02, 16'h4800);
    tick(); expect_out("s3", 8'h03, 16'h6200);

    // Stall three cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("stall", 8'h03, 16'h6200);
      check("stall_addr", 32'(imem_addr), 32'h04);
    end
    out_ready = 1'b1;
    tick(); expect_out("release", 8'h04, 16'h68A8);

    // Redirect while 07 is pending and not accepted
    tick(); tick(); tick();
    expect_out("pend07", 8'h07, 16'h68A8);
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h12;
    tick();
    check("redir_flush", 32'(out_valid), 32'd0);
    check("redir_addr", 32'(imem_addr), 32'h12);
    redirect_valid = 1'b0; out_ready = 1'b1;
    tick(); expect_out("redir_tgt", 8'h12, 16'h0D80);

    // Run into the halt at 15
    tick(); tick(); tick();
    expect_out("halt_word", 8'h15, 16'hF800);
    check("halted_set", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_idle", 32'(out_valid), 32'd0);
      check("halt_addr", 32'(imem_addr), 32'h16);
    end

    // Resume from HALT
    resume = 1'b1;
    tick();
    check("resume_clr", 32'(halted), 32'd0);
    resume = 1'b0;
    tick(); expect_out("resume_word", 8'h16, 16'h0000);

    // Redirect out of HALT, with resume in the same cycle
    redirect_valid = 1'b1; redirect_pc = 8'h15;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    check("halt2", 32'(halted), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 8'h00; resume = 1'b1;
    tick();
    check("halt_redir_clr", 32'(halted), 32'd0);
    redirect_valid = 1'b0; resume = 1'b0;
    tick(); expect_out("halt_redir", 8'h00, 16'h4A0A);

    // PC wrap on an all-zero ROM, then reset during a stall
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    tick(); expect_out("wrap_fe", 8'hFE, 16'h0000);
    tick(); expect_out("wrap_ff", 8'hFF, 16'h0000);
    tick(); expect_out("wrap_00", 8'h00, 16'h0000);
    out_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("stall_rst_valid", 32'(out_valid), 32'd0);
    check("stall_rst_addr", 32'(imem_addr), 32'h00);

    // Random traffic with scattered halt words
    fill_rom(12);
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 299) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 8'($urandom);
      resume         = ($urandom_range(0, 5) == 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
